weight_buf: RTL and testbench

WEIGHT_BUF -- requirements
Module: weight_buf

---
 rtl/weight_buf_if.sv | 31 +++
 rtl/weight_buf.sv | 90 +++++++++
 tb/tb_weight_buf.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/weight_buf_if.sv
// weight_buf_if: load, stream and random-read signals of the kernel weight buffer
interface weight_buf_if #(parameter int ROWS = 8, parameter int WW = 8);
  localparam int RW = 9 * WW;
  localparam int AW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + 1);
  logic          load_start;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [RW-1:0] wr_data;
  logic          stream_start;
  logic          out_ready;
  logic          out_valid;
  logic [RW-1:0] out_data;
  logic [AW-1:0] out_row;
  logic          stream_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [RW-1:0] rd_data;
  logic [CW-1:0] fill_count;
  logic          full;
  logic [1:0]    state;
  modport master (
    output load_start, wr_en, wr_addr, wr_data, stream_start, out_ready, rd_en, rd_addr,
    input  out_valid, out_data, out_row, stream_done, rd_valid, rd_data, fill_count, full, state
  );
  modport slave (
    input  load_start, wr_en, wr_addr, wr_data, stream_start, out_ready, rd_en, rd_addr,
    output out_valid, out_data, out_row, stream_done, rd_valid, rd_data, fill_count, full, state
  );
endinterface

// File: rtl/weight_buf.sv
// weight_buf: kernel row store with load tracking, sequential row streaming and random reads
module weight_buf #(
  parameter int ROWS = 8,
  parameter int WW   = 8
) (
  input logic        clk,
  input logic        rst,
  weight_buf_if.slave b
);
  localparam int RW = 9 * WW;
  localparam int AW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + 1);
  typedef enum logic [1:0] {IDLE, LOAD, READY, STREAM} st_t;
  st_t           st;
  logic [RW-1:0] mem [ROWS];
  logic [ROWS-1:0] vld, vld_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          wr_ok, fresh, ov, done, rv;
  logic [RW-1:0] odata, rdata;
  logic [AW-1:0] orow, nrow;
  assign b.state       = st;
  assign b.fill_count  = cnt;
  assign b.full        = cnt == CW'(ROWS);
  assign b.out_valid   = ov;
  assign b.out_data    = odata;
  assign b.out_row     = orow;
  assign b.stream_done = done;
  assign b.rd_valid    = rv;
  assign b.rd_data     = rdata;
  // a write landing with load_start is the first row of the new load
  always_comb begin
    wr_ok = b.wr_en && (b.load_start || st == LOAD);
    fresh = b.load_start || !vld[b.wr_addr];
    cnt_n = (b.load_start ? '0 : cnt) + CW'(wr_ok && fresh);
    vld_n = (b.load_start ? '0 : vld) | (wr_ok ? ROWS'(1) << b.wr_addr : '0);
    nrow  = orow + AW'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= IDLE;
      vld   <= '0;
      cnt   <= '0;
      ov    <= 1'b0;
      odata <= '0;
      orow  <= '0;
      done  <= 1'b0;
      rv    <= 1'b0;
      rdata <= '0;
      for (int i = 0; i < ROWS; i++) mem[i] <= '0;
    end else begin
      done <= 1'b0;
      rv   <= 1'b0;
      vld  <= vld_n;
      cnt  <= cnt_n;
      if (wr_ok) mem[b.wr_addr] <= b.wr_data;
      if (b.load_start) begin
        st <= cnt_n == CW'(ROWS) ? READY : LOAD;
        ov <= 1'b0;
      end else begin
        case (st)
          IDLE: ;
          LOAD: if (cnt_n == CW'(ROWS)) st <= READY;
          READY: begin
            if (b.rd_en) begin
              rv    <= 1'b1;
              rdata <= mem[b.rd_addr];
            end
            if (b.stream_start) begin
              st    <= STREAM;
              ov    <= 1'b1;
              orow  <= '0;
              odata <= mem[0];
            end
          end
          STREAM: if (ov && b.out_ready) begin
            if (orow == AW'(ROWS - 1)) begin
              ov   <= 1'b0;
              done <= 1'b1;
              st   <= READY;
            end else begin
              orow  <= nrow;
              odata <= mem[nrow];
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_weight_buf.sv
// tb_weight_buf: directed stimulus with queued expectations checked by a monitor
module tb_weight_buf;
  typedef struct { logic [2:0] row; logic [71:0] data; } srow_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  weight_buf_if b ();
  weight_buf dut (.clk(clk), .rst(rst), .b(b));
  srow_t       sq[$];
  logic [71:0] rq[$];
  logic [71:0] mdl [8];
  int n_chk = 0, n_fail = 0, done_cnt = 0;

  task automatic chk(input string n, input logic [71:0] a, input logic [71:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [71:0] d, input int f, input int s);
    b.wr_en = 1; b.wr_addr = 3'(a); b.wr_data = d;
    tick();
    b.wr_en = 0;
    chk("fill_after_wr", 72'(b.fill_count), 72'(f));
    chk("state_after_wr", 72'(b.state), 72'(s));
  endtask

  task automatic rd(input int a, input bit ok);
    b.rd_en = 1; b.rd_addr = 3'(a);
    if (ok) rq.push_back(mdl[a]);
    tick();
    b.rd_en = 0;
    chk("rd_valid", 72'(b.rd_valid), 72'(ok));
    tick();
    chk("rd_valid_pulse", 72'(b.rd_valid), 72'(0));
  endtask

  task automatic run_stream(input int srow, input int sn);
    int cyc = 0, stalled = 0, d0 = done_cnt;
    for (int i = 0; i < 8; i++) sq.push_back('{3'(i), mdl[i]});
    b.stream_start = 1; b.out_ready = 1;
    tick();
    b.stream_start = 0;
    chk("stream_first_row", 72'(b.out_row), 72'(0));
    while (!b.stream_done && cyc < 50) begin
      if (int'(b.out_row) == srow && stalled < sn) begin
        b.out_ready = 0; stalled++;
      end else b.out_ready = 1;
      tick();
      cyc++;
    end
    chk("stream_cycles", 72'(cyc), 72'(8 + sn));
    chk("stream_valid_drop", 72'(b.out_valid), 72'(0));
    tick();
    chk("stream_done_pulse", 72'(b.stream_done), 72'(0));
    chk("stream_done_count", 72'(done_cnt), 72'(d0 + 1));
    chk("state_after_stream", 72'(b.state), 72'(2));
  endtask

  always @(negedge clk) begin
    if (b.out_valid) begin
      if (sq.size() == 0) chk("stream_unexpected", 72'(b.out_row), 72'hx);
      else begin
        chk("out_row", 72'(b.out_row), 72'(sq[0].row));
        chk("out_data", b.out_data, sq[0].data);
        if (b.out_ready) void'(sq.pop_front());
      end
    end
    if (b.rd_valid) begin
      if (rq.size() == 0) chk("rd_unexpected", b.rd_data, 72'hx);
      else chk("rd_data", b.rd_data, rq.pop_front());
    end
    if (b.stream_done) done_cnt++;
  end

  initial begin
    int d0;
    b.load_start = 0; b.wr_en = 0; b.wr_addr = 0; b.wr_data = 0;
    b.stream_start = 0; b.out_ready = 0; b.rd_en = 0; b.rd_addr = 0;
    for (int i = 0; i < 8; i++) mdl[i] = 0;
    tick(); tick();
    chk("rst_state", 72'(b.state), 72'(0));
    chk("rst_fill", 72'(b.fill_count), 72'(0));
    chk("rst_full", 72'(b.full), 72'(0));
    chk("rst_out_valid", 72'(b.out_valid), 72'(0));
    chk("rst_out_data", b.out_data, 72'(0));
    chk("rst_rd_data", b.rd_data, 72'(0));
    rst = 0;
    tick();
    b.load_start = 1;
    tick();
    b.load_start = 0;
    chk("load_state", 72'(b.state), 72'(1));
    chk("load_fill", 72'(b.fill_count), 72'(0));
    for (int i = 0; i < 8; i++) begin
      mdl[i] = 72'(i + 1);
      wr(i, mdl[i], i + 1, i == 7 ? 2 : 1);
    end
    chk("full_after_load", 72'(b.full), 72'(1));
    wr(2, 72'hFF, 8, 2);
    run_stream(-1, 0);
    run_stream(4, 3);
    rd(5, 1);
    chk("rd5_model", mdl[5], 72'h06);
    for (int i = 0; i < 3; i++) sq.push_back('{3'(i), mdl[i]});
    d0 = done_cnt;
    b.stream_start = 1; b.out_ready = 1;
    tick();
    b.stream_start = 0;
    tick(); tick();
    chk("abort_row", 72'(b.out_row), 72'(2));
    b.load_start = 1;
    tick();
    b.load_start = 0;
    chk("abort_valid", 72'(b.out_valid), 72'(0));
    chk("abort_state", 72'(b.state), 72'(1));
    chk("abort_fill", 72'(b.fill_count), 72'(0));
    repeat (3) tick();
    chk("abort_no_done", 72'(done_cnt), 72'(d0));
    chk("abort_queue", 72'(sq.size()), 72'(0));
    rd(5, 0);
    b.load_start = 1; b.wr_en = 1; b.wr_addr = 0; b.wr_data = 72'h11;
    mdl[0] = 72'h11;
    tick();
    b.load_start = 0; b.wr_en = 0;
    chk("coincident_fill", 72'(b.fill_count), 72'(1));
    chk("coincident_state", 72'(b.state), 72'(1));
    mdl[3] = 72'hBB;
    wr(3, 72'hAA, 2, 1);
    wr(3, 72'hBB, 2, 1);
    wr(1, 72'h21, 3, 1); mdl[1] = 72'h21;
    wr(2, 72'h22, 4, 1); mdl[2] = 72'h22;
    wr(4, 72'h24, 5, 1); mdl[4] = 72'h24;
    wr(5, 72'h25, 6, 1); mdl[5] = 72'h25;
    wr(6, 72'h26, 7, 1); mdl[6] = 72'h26;
    wr(7, 72'h27, 8, 2); mdl[7] = 72'h27;
    rd(3, 1);
    rd(5, 1);
    for (int i = 0; i < 8; i++) sq.push_back('{3'(i), mdl[i]});
    b.stream_start = 1; b.out_ready = 1;
    tick();
    b.stream_start = 0;
    tick();
    #3;
    rst = 1;
    sq.delete();
    #1;
    chk("rst_mid_valid", 72'(b.out_valid), 72'(0));
    chk("rst_mid_data", b.out_data, 72'(0));
    chk("rst_mid_row", 72'(b.out_row), 72'(0));
    chk("rst_mid_state", 72'(b.state), 72'(0));
    chk("rst_mid_fill", 72'(b.fill_count), 72'(0));
    chk("rst_mid_full", 72'(b.full), 72'(0));
    chk("rst_mid_done", 72'(b.stream_done), 72'(0));
    tick();
    rst = 0;
    b.wr_en = 1; b.wr_addr = 2; b.wr_data = 72'h55;
    tick();
    b.wr_en = 0;
    tick();
    chk("idle_wr_fill", 72'(b.fill_count), 72'(0));
    chk("idle_wr_state", 72'(b.state), 72'(0));
    b.stream_start = 1;
    tick();
    b.stream_start = 0;
    chk("idle_stream_valid", 72'(b.out_valid), 72'(0));
    chk("idle_stream_state", 72'(b.state), 72'(0));
    tick();
    chk("end_stream_queue", 72'(sq.size()), 72'(0));
    chk("end_rd_queue", 72'(rq.size()), 72'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
